spi_mem_arbiter: RTL and testbench

//  Shares the single SPI memory engine between two requesters: instruction fetch (control unit) and

---
 rtl/spi_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_spi_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Arbitrates the SPI memory engine between instruction fetch and data access, one transaction at a time.
// state | meaning: IDLE wait for grant | ISSUE start pulse to engine | WAIT await spi_done or timeout | RESP done pulse to owner
module spi_mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          spi_start,
  output logic          spi_we,
  output logic [AW-1:0] spi_addr,
  output logic [DW-1:0] spi_wdata,
  input  logic          spi_done,
  input  logic [DW-1:0] spi_rdata,
  output logic          busy,
  output logic          timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic [TW-1:0] timer;
  logic          grant_d;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    grant_d = d_req && (!f_req || (last_owner == OWN_F));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_D;
      last_owner  <= OWN_D;
      timer       <= '0;
      spi_start   <= 1'b0;
      spi_we      <= 1'b0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
      f_done      <= 1'b0;
      f_rdata     <= '0;
      d_done      <= 1'b0;
      d_rdata     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt && (f_req || d_req)) begin
            owner      <= grant_d;
            last_owner <= grant_d;
            spi_we     <= grant_d ? d_we : 1'b0;
            spi_addr   <= grant_d ? d_addr : f_addr;
            spi_wdata  <= grant_d ? d_wdata : '0;
            spi_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Down-counter: WAIT lasts at most TIMEOUT+1 cycles before aborting.
          timer <= TW'(TIMEOUT);
          state <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            if (owner == OWN_D) begin
              d_rdata <= spi_rdata;
              d_done  <= 1'b1;
            end else begin
              f_rdata <= spi_rdata;
              f_done  <= 1'b1;
            end
            state <= RESP;
          end else if (timer == '0) begin
            if (owner == OWN_D) begin
              d_rdata <= '1;
              d_done  <= 1'b1;
            end else begin
              f_rdata <= '1;
              f_done  <= 1'b1;
            end
            timeout_err <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: fetch/data transactions, round robin, timeout, halt, reset.
module tb_spi_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_done;
  logic [DW-1:0] f_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          spi_start;
  logic          spi_we;
  logic [AW-1:0] spi_addr;
  logic [DW-1:0] spi_wdata;
  logic          spi_done;
  logic [DW-1:0] spi_rdata;
  logic          busy;
  logic          timeout_err;

  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;
  int n_fdone  = 0;
  int n_ddone  = 0;

  spi_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .spi_start(spi_start), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_done(spi_done), .spi_rdata(spi_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_start === 1'b1) n_start++;
    if (f_done === 1'b1) n_fdone++;
    if (d_done === 1'b1) n_ddone++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (spi_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, {31'd0, spi_start}, 32'd1);
  endtask

  task automatic engine_done(input logic [DW-1:0] rd);
    spi_rdata = rd;
    spi_done  = 1'b1;
    step();
    spi_done  = 1'b0;
  endtask

  initial begin
    int n;
    int s0;
    rst = 1'b1; halt = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    spi_done = 1'b0; spi_rdata = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_start", spi_start, 0);
    check("rst_addr", spi_addr, 0);
    check("rst_fdone", f_done, 0);
    check("rst_rdata", {f_rdata, d_rdata}, 0);
    check("rst_terr", timeout_err, 0);
    rst = 1'b0;
    step();

    // 1: fetch read
    f_req = 1'b1; f_addr = 16'h0123; d_addr = 16'hFFFF;
    wait_start("t1_start");
    check("t1_addr", spi_addr, 32'h0123);
    check("t1_we", spi_we, 0);
    check("t1_busy", busy, 1);
    f_addr = 16'hDEAD;
    step(); step();
    engine_done(8'hA5);
    check("t1_fdone", f_done, 1);
    check("t1_frdata", f_rdata, 32'hA5);
    check("t1_ddone", d_done, 0);
    f_req = 1'b0;
    step();
    check("t1_fdone_off", f_done, 0);
    check("t1_idle", busy, 0);
    check("t1_nstart", n_start, 1);
    check("t1_nfdone", n_fdone, 1);

    // 2: data write; spi_done during ISSUE is ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wdata = 8'h3C;
    wait_start("t2_start");
    check("t2_we", spi_we, 1);
    check("t2_addr", spi_addr, 32'h8000);
    check("t2_wdata", spi_wdata, 32'h3C);
    spi_done = 1'b1; spi_rdata = 8'h77;
    step();
    spi_done = 1'b0;
    check("t2_early_done", d_done, 0);
    check("t2_still_busy", busy, 1);
    step();
    engine_done(8'h11);
    check("t2_ddone", d_done, 1);
    check("t2_fdone", f_done, 0);
    d_req = 1'b0;
    step();
    check("t2_nddone", n_ddone, 1);
    check("t2_fhold", f_rdata, 32'hA5);

    // 3: continuous contention alternates F,D,F,D
    f_addr = 16'h1111; d_addr = 16'h2222; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("t3_start%0d", i));
      check($sformatf("t3_owner%0d", i), spi_addr, (i % 2 == 0) ? 32'h1111 : 32'h2222);
      step();
      engine_done(8'h40 + 8'(i));
      if (i % 2 == 0) begin
        check($sformatf("t3_done%0d", i), {30'd0, f_done, d_done}, 32'b10);
        check($sformatf("t3_rd%0d", i), f_rdata, 32'h40 + i);
      end else begin
        check($sformatf("t3_done%0d", i), {30'd0, f_done, d_done}, 32'b01);
        check($sformatf("t3_rd%0d", i), d_rdata, 32'h40 + i);
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    step(); step();

    // 4: timeout (TIMEOUT=8)
    f_req = 1'b1; f_addr = 16'h0BAD;
    wait_start("t4_start");
    n = 0;
    while (f_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("t4_latency", (n >= 9 && n <= 10) ? 1 : 0, 1);
    check("t4_frdata", f_rdata, 32'hFF);
    check("t4_terr", timeout_err, 1);
    f_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0042;
    wait_start("t4_good_start");
    step();
    engine_done(8'hC3);
    check("t4_good_ddone", d_done, 1);
    check("t4_good_rdata", d_rdata, 32'hC3);
    d_req = 1'b0;
    step();
    check("t4_terr_sticky", timeout_err, 1);

    // 5: halt blocks grants but not an in-flight transaction
    halt = 1'b1; f_req = 1'b1; f_addr = 16'h0555;
    s0 = n_start;
    repeat (5) step();
    check("t5_halt_nostart", n_start - s0, 0);
    check("t5_halt_idle", busy, 0);
    halt = 1'b0;
    wait_start("t5_start");
    step();
    halt = 1'b1;
    step();
    engine_done(8'h5A);
    check("t5_fdone", f_done, 1);
    check("t5_frdata", f_rdata, 32'h5A);
    f_req = 1'b0; d_req = 1'b1; d_addr = 16'h0666;
    s0 = n_start;
    repeat (4) step();
    check("t5_halt_hold", n_start - s0, 0);
    halt = 1'b0;
    wait_start("t5_after_halt");
    check("t5_addr", spi_addr, 32'h0666);
    step();
    engine_done(8'h66);
    d_req = 1'b0;
    step();

    // 6: reset during WAIT
    f_req = 1'b1; f_addr = 16'h0777;
    wait_start("t6_start");
    step();
    s0 = n_fdone;
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_outs", {29'd0, spi_start, f_done, d_done}, 0);
    check("t6_terr", timeout_err, 0);
    step();
    rst = 1'b0;
    wait_start("t6_restart");
    check("t6_addr", spi_addr, 32'h0777);
    check("t6_no_done", n_fdone - s0, 0);
    step();
    engine_done(8'h9E);
    check("t6_fdone", f_done, 1);
    check("t6_frdata", f_rdata, 32'h9E);
    f_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
